// File: rtl/lbp_pkg.sv
// Shared LBP definitions: FSM states, neighbour index map,
// and a clog2 helper for counter sizing.
package lbp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SHIFT,
    CALC,
    OUT,
    ZERO,
    DONE
  } state_t;

  // Window slots are row-major 0..8, centre in slot 4.
  localparam int CTR_IDX = 4;
  localparam int NB_IDX [8] = '{0, 1, 2, 3, 5, 6, 7, 8};

  function automatic int clog2(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) n = i + 1;
    end
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/lbp_code_calc.sv
// Combinational 3x3 LBP code: win (9 pixels, row-major), thr -> code.
// Bit i set when neighbour NB_IDX[i] >= centre + thr (no wrap).
module lbp_code_calc
  import lbp_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [8:0][DW-1:0] win,
  input  logic [DW-1:0]      thr,
  output logic [7:0]         code
);

  // One extra bit so a centre+thr overflow can never match.
  logic [DW:0] lvl;

  assign lvl = {1'b0, win[CTR_IDX]} + {1'b0, thr};

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign code[i] = ({1'b0, win[NB_IDX[i]]} >= lvl);
  end

endmodule

// File: rtl/lbp_engine.sv
// Raster-order 3x3 LBP engine over a sync-read frame memory.
// Ports: gray_* read side, lbp_* valid/ready code output, finish.
module lbp_engine
  import lbp_pkg::*;
#(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int DW          = 8,
  parameter int AW          = 14,
  parameter int BORDER_ZERO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] thr,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  output logic          lbp_valid,
  input  logic          lbp_ready,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  localparam int RW = clog2(IMG_H);
  localparam int CW = clog2(IMG_W);

  state_t               state;
  logic [RW-1:0]        r;
  logic [CW-1:0]        c;
  logic [3:0]           k;
  logic [8:0][DW-1:0]   win;
  logic [DW-1:0]        thr_q;
  logic [7:0]           code;

  logic [RW-1:0]        tr;
  logic [CW-1:0]        tc;
  logic                 tend;
  logic                 tborder;
  logic                 go;

  function automatic logic [AW-1:0] pix(
    input logic [AW-1:0] row,
    input logic [AW-1:0] col
  );
    return row * AW'(IMG_W) + col;
  endfunction

  lbp_code_calc #(.DW(DW)) u_calc (
    .win  (win),
    .thr  (thr_q),
    .code (code)
  );

  // Target pixel of the next launch: first pixel from IDLE,
  // otherwise the raster successor of (r,c).
  always_comb begin
    tr   = r;
    tc   = c;
    tend = 1'b0;
    if (state == IDLE) begin
      tr = (BORDER_ZERO != 0) ? '0 : RW'(1);
      tc = (BORDER_ZERO != 0) ? '0 : CW'(1);
    end else if (BORDER_ZERO != 0) begin
      tend = (r == RW'(IMG_H - 1)) && (c == CW'(IMG_W - 1));
      if (c == CW'(IMG_W - 1)) begin
        tr = r + RW'(1);
        tc = '0;
      end else begin
        tc = c + CW'(1);
      end
    end else begin
      tend = (r == RW'(IMG_H - 2)) && (c == CW'(IMG_W - 2));
      if (c == CW'(IMG_W - 2)) begin
        tr = r + RW'(1);
        tc = CW'(1);
      end else begin
        tc = c + CW'(1);
      end
    end
    tborder = (tr == '0) || (tr == RW'(IMG_H - 1)) ||
              (tc == '0) || (tc == CW'(IMG_W - 1));
    go = ((state == IDLE) && gray_ready) ||
         (((state == OUT) || (state == ZERO)) && lbp_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      k         <= '0;
      win       <= '0;
      thr_q     <= '0;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
    end else if (go) begin
      r <= tr;
      c <= tc;
      k <= '0;
      if (state == IDLE) thr_q <= thr;
      if (tend) begin
        state     <= DONE;
        lbp_valid <= 1'b0;
        finish    <= 1'b1;
      end else if (tborder) begin
        state     <= ZERO;
        lbp_valid <= 1'b1;
        lbp_addr  <= pix(AW'(tr), AW'(tc));
        lbp_data  <= '0;
      end else if (tc == CW'(1)) begin
        state     <= FILL;
        lbp_valid <= 1'b0;
        gray_req  <= 1'b1;
        gray_addr <= pix(AW'(tr) - AW'(1), AW'(tc) - AW'(1));
      end else begin
        state     <= SHIFT;
        lbp_valid <= 1'b0;
        gray_req  <= 1'b1;
        gray_addr <= pix(AW'(tr) - AW'(1), AW'(tc) + AW'(1));
        for (int i = 0; i < 3; i++) begin
          win[3*i]   <= win[3*i+1];
          win[3*i+1] <= win[3*i+2];
        end
      end
    end else begin
      unique case (state)
        FILL: begin
          // Data for request k-1 lands while k is presented.
          if (k != 4'd0) win[k - 4'd1] <= gray_data;
          if (k < 4'd8) begin
            gray_req  <= 1'b1;
            gray_addr <= gray_addr +
              (((k == 4'd2) || (k == 4'd5)) ?
                AW'(IMG_W - 2) : AW'(1));
          end else begin
            gray_req <= 1'b0;
          end
          if (k == 4'd9) state <= CALC;
          else k <= k + 4'd1;
        end
        SHIFT: begin
          unique case (k)
            4'd1:    win[2] <= gray_data;
            4'd2:    win[5] <= gray_data;
            4'd3:    win[8] <= gray_data;
            default: ;
          endcase
          if (k < 4'd2) begin
            gray_req  <= 1'b1;
            gray_addr <= gray_addr + AW'(IMG_W);
          end else begin
            gray_req <= 1'b0;
          end
          if (k == 4'd3) state <= CALC;
          else k <= k + 4'd1;
        end
        CALC: begin
          state     <= OUT;
          lbp_valid <= 1'b1;
          lbp_addr  <= pix(AW'(r), AW'(c));
          lbp_data  <= code;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_engine.sv
// Directed bench for lbp_engine: interior-only 6x5 instance and
// border-zero 5x4 instance, hand-computed codes and timing.
module tb_lbp_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] a_thr, a_gaddr, a_gdata, a_addr, a_data;
  logic       a_gready, a_req, a_valid, a_ready, a_fin;
  logic [7:0] b_thr, b_gaddr, b_gdata, b_addr, b_data;
  logic       b_gready, b_req, b_valid, b_ready, b_fin;

  lbp_engine #(
    .IMG_W(6), .IMG_H(5), .DW(8), .AW(8), .BORDER_ZERO(0)
  ) u_a (
    .clk(clk), .reset(reset), .thr(a_thr),
    .gray_ready(a_gready), .gray_req(a_req),
    .gray_addr(a_gaddr), .gray_data(a_gdata),
    .lbp_valid(a_valid), .lbp_ready(a_ready),
    .lbp_addr(a_addr), .lbp_data(a_data), .finish(a_fin)
  );

  lbp_engine #(
    .IMG_W(5), .IMG_H(4), .DW(8), .AW(8), .BORDER_ZERO(1)
  ) u_b (
    .clk(clk), .reset(reset), .thr(b_thr),
    .gray_ready(b_gready), .gray_req(b_req),
    .gray_addr(b_gaddr), .gray_data(b_gdata),
    .lbp_valid(b_valid), .lbp_ready(b_ready),
    .lbp_addr(b_addr), .lbp_data(b_data), .finish(b_fin)
  );

  logic [7:0] mem_a [30];
  logic [7:0] mem_b [20];
  always @(posedge clk) if (a_req) a_gdata <= mem_a[a_gaddr];
  always @(posedge clk) if (b_req) b_gdata <= mem_b[b_gaddr];

  int qa_addr[$], qa_data[$], qa_cyc[$];
  int qb_addr[$], qb_data[$], qb_cyc[$];
  int a_reads, a_req0_cyc, a_req0_addr, a_fin_cyc;
  int b_reads, b_req_out, b_fin_cyc;

  always @(negedge clk) begin
    if (!reset) begin
      if (a_valid && a_ready) begin
        qa_addr.push_back(int'(a_addr));
        qa_data.push_back(int'(a_data));
        qa_cyc.push_back(cyc);
      end
      if (a_req) begin
        a_reads <= a_reads + 1;
        if (a_req0_cyc < 0) begin
          a_req0_cyc  <= cyc;
          a_req0_addr <= int'(a_gaddr);
        end
      end
      if (a_fin && a_fin_cyc < 0) a_fin_cyc <= cyc;
      if (b_valid && b_ready) begin
        qb_addr.push_back(int'(b_addr));
        qb_data.push_back(int'(b_data));
        qb_cyc.push_back(cyc);
      end
      if (b_req) b_reads <= b_reads + 1;
      if (b_req && b_valid) b_req_out <= b_req_out + 1;
      if (b_fin && b_fin_cyc < 0) b_fin_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    qa_addr.delete(); qa_data.delete(); qa_cyc.delete();
    qb_addr.delete(); qb_data.delete(); qb_cyc.delete();
    a_reads = 0; a_req0_cyc = -1; a_req0_addr = -1; a_fin_cyc = -1;
    b_reads = 0; b_req_out = 0; b_fin_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_gready = 1'b0; b_gready = 1'b0;
    a_ready = 1'b1;  b_ready = 1'b1;
    a_thr = '0; b_thr = '0;
    clr_mon();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // kind 0: flat val, 1: pixel=col, 2: pixel=row*10
  task automatic load_a(input int kind, input int val);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++)
        mem_a[r*6+c] = (kind == 0) ? val[7:0] :
                       (kind == 1) ? c[7:0] : 8'(r * 10);
  endtask

  task automatic start_a(input logic [7:0] thr);
    a_thr = thr;
    @(posedge clk); #1 a_gready = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_gready = 1'b0;
    a_thr = ~thr;
  endtask

  task automatic wait_fin_a(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (a_fin) break;
    end
    chk({name, " finish"}, a_fin, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_stall(input logic [7:0] code);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (qa_addr.size() >= 2) break;
    end
    a_ready = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (a_valid) break;
    end
    for (int j = 0; j < 7; j++) begin
      if (j > 0) @(negedge clk);
      chk("stall valid", a_valid, 1);
      chk("stall addr", a_addr, 9);
      chk("stall data", a_data, code);
      chk("stall req", a_req, 0);
    end
    @(posedge clk); #1 a_ready = 1'b1;
  endtask

  int exp_a [12] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22};

  task automatic check_a(input string name, input logic [7:0] code,
                         input bit stall);
    int n;
    n = qa_addr.size();
    chk({name, " count"}, n, 12);
    for (int i = 0; i < n && i < 12; i++) begin
      chk({name, " addr"}, qa_addr[i], exp_a[i]);
      chk({name, " code"}, qa_data[i], code);
    end
    chk({name, " req0 addr"}, a_req0_addr, 0);
    chk({name, " reads"}, a_reads, 54);
    if (n >= 3) begin
      chk({name, " lat"}, qa_cyc[0] - a_req0_cyc, 11);
      chk({name, " gap2"}, qa_cyc[1] - qa_cyc[0], 6);
      chk({name, " gap3"}, qa_cyc[2] - qa_cyc[1], stall ? 13 : 6);
      chk({name, " fin"}, a_fin_cyc - qa_cyc[n-1], 1);
    end
  endtask

  task automatic run_a(input string name, input int kind, input int val,
                       input logic [7:0] thr, input logic [7:0] code,
                       input bit stall);
    do_reset();
    load_a(kind, val);
    start_a(thr);
    if (stall) do_stall(code);
    wait_fin_a(name);
    check_a(name, code, stall);
  endtask

  initial begin
    do_reset();
    chk("rst a_valid", a_valid, 0);
    chk("rst a_req", a_req, 0);
    chk("rst a_fin", a_fin, 0);
    chk("rst b_valid", b_valid, 0);
    chk("rst b_addr", b_addr, 0);

    run_a("flat50", 0, 50, 8'd0, 8'hFF, 1'b0);
    run_a("ramp_t0", 1, 0, 8'd0, 8'hD6, 1'b1);
    run_a("ramp_t1", 1, 0, 8'd1, 8'h94, 1'b0);
    run_a("vramp", 2, 0, 8'd0, 8'hF8, 1'b0);
    run_a("flat255_t1", 0, 255, 8'd1, 8'h00, 1'b0);

    // Abort during SHIFT of the second output row, then restart.
    do_reset();
    load_a(1, 0);
    start_a(8'd0);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (qa_addr.size() >= 5) break;
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort gray_req", a_req, 0);
    chk("abort gray_addr", a_gaddr, 0);
    chk("abort valid", a_valid, 0);
    chk("abort lbp_addr", a_addr, 0);
    chk("abort lbp_data", a_data, 0);
    chk("abort finish", a_fin, 0);
    clr_mon();
    a_thr = 8'd0;
    a_gready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 a_gready = 1'b0;
    wait_fin_a("restart");
    check_a("restart", 8'hD6, 1'b0);

    // Border-zero instance: full raster, ramp pixel=col, thr=0.
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        mem_b[r*5+c] = c[7:0];
    @(posedge clk); #1 b_gready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (b_fin) break;
    end
    chk("bz finish", b_fin, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("bz count", qb_addr.size(), 20);
    for (int i = 0; i < qb_addr.size() && i < 20; i++) begin
      int r, c;
      r = i / 5;
      c = i % 5;
      chk("bz addr", qb_addr[i], i);
      chk("bz code", qb_data[i],
          (r == 0 || r == 3 || c == 0 || c == 4) ? 0 : 32'hD6);
    end
    chk("bz reads", b_reads, 30);
    chk("bz req in out", b_req_out, 0);
    if (qb_cyc.size() >= 20) begin
      chk("bz zero rate", qb_cyc[4] - qb_cyc[0], 4);
      chk("bz fin", b_fin_cyc - qb_cyc[19], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
